// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Brief    : 3-stage IEEE-style floating-point adder/subtractor with
//            RNE/RTZ rounding, valid/ready handshakes and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     opcode,
    input  logic                     sign1,
    input  logic                     sign2,
    input  logic [EXP_W-1:0]         exp1,
    input  logic [EXP_W-1:0]         exp2,
    input  logic [SIG_W-1:0]         sig1,
    input  logic [SIG_W-1:0]         sig2,
    input  logic                     rm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+SIG_W:0]     fp_out,
    output logic [2:0]               err_o
);

    localparam int FW   = 1 + EXP_W + SIG_W;
    localparam int M    = SIG_W + 1;          // significand incl. hidden bit
    localparam int AW   = M + 3;              // + guard, round, sticky
    localparam int SW   = AW + 1;             // + carry
    localparam int XW0  = EXP_W + 2;
    localparam int XW1  = $clog2(SW) + 1;
    localparam int XW   = (XW0 > XW1) ? XW0 : XW1;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OVF   = 3'd1;
    localparam logic [2:0] ERR_UNF   = 3'd2;
    localparam logic [2:0] ERR_INV   = 3'd3;

    localparam logic [XW-1:0] EMAX   = XW'((1 << EXP_W) - 1);
    localparam logic [XW-1:0] XONE   = XW'(1);

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- Stage 1: classify, swap, align ----------------
    logic             w_s2e;
    logic             w_nan1, w_nan2, w_inf1, w_inf2;
    logic             w_swap;
    logic             w_sb;
    logic [EXP_W-1:0] w_exb, w_exs;
    logic [SIG_W-1:0] w_frb, w_frs;
    logic [M-1:0]     w_mb, w_ms;
    logic [XW-1:0]    w_eb, w_es, w_diff;
    logic [2*(M+2)-1:0] w_wide, w_shr;
    logic [AW-1:0]    w_small;
    logic             w_spec;
    logic [FW-1:0]    w_spec_val;
    logic [2:0]       w_spec_err;

    assign w_s2e  = sign2 ^ opcode;
    assign w_nan1 = (&exp1) && (|sig1);
    assign w_nan2 = (&exp2) && (|sig2);
    assign w_inf1 = (&exp1) && !(|sig1);
    assign w_inf2 = (&exp2) && !(|sig2);

    // Ordering by raw {exp, frac} is magnitude ordering, denormals included.
    assign w_swap = {exp2, sig2} > {exp1, sig1};
    assign w_sb   = w_swap ? w_s2e : sign1;
    assign w_exb  = w_swap ? exp2 : exp1;
    assign w_exs  = w_swap ? exp1 : exp2;
    assign w_frb  = w_swap ? sig2 : sig1;
    assign w_frs  = w_swap ? sig1 : sig2;
    assign w_mb   = {|w_exb, w_frb};
    assign w_ms   = {|w_exs, w_frs};
    assign w_eb   = (w_exb == '0) ? XONE : {{(XW-EXP_W){1'b0}}, w_exb};
    assign w_es   = (w_exs == '0) ? XONE : {{(XW-EXP_W){1'b0}}, w_exs};
    assign w_diff = w_eb - w_es;

    assign w_wide  = {w_ms, 2'b00, {(M+2){1'b0}}};
    assign w_shr   = w_wide >> w_diff;
    assign w_small = (w_diff >= XW'(M+2)) ? {{(M+2){1'b0}}, |w_ms}
                                          : {w_shr[2*(M+2)-1:M+2], |w_shr[M+1:0]};

    always_comb begin
        w_spec     = 1'b0;
        w_spec_val = '0;
        w_spec_err = ERR_NONE;
        if (w_nan1 || w_nan2 || (w_inf1 && w_inf2 && (sign1 != w_s2e))) begin
            w_spec     = 1'b1;
            w_spec_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
            w_spec_err = ERR_INV;
        end else if (w_inf1) begin
            w_spec     = 1'b1;
            w_spec_val = {sign1, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
        end else if (w_inf2) begin
            w_spec     = 1'b1;
            w_spec_val = {w_s2e, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
        end
    end

    logic             r1_valid, r1_spec, r1_sign, r1_sub, r1_rm;
    logic [FW-1:0]    r1_spec_val;
    logic [2:0]       r1_spec_err;
    logic [XW-1:0]    r1_exp;
    logic [AW-1:0]    r1_mb, r1_ms;

    // ---------------- Stage 2: significand add/subtract ----------------
    logic [SW-1:0]    w_sum;
    assign w_sum = r1_sub ? ({1'b0, r1_mb} - {1'b0, r1_ms})
                          : ({1'b0, r1_mb} + {1'b0, r1_ms});

    logic             r2_valid, r2_spec, r2_sign, r2_sub, r2_rm;
    logic [FW-1:0]    r2_spec_val;
    logic [2:0]       r2_spec_err;
    logic [XW-1:0]    r2_exp;
    logic [SW-1:0]    r2_sum;

    // ---------------- Stage 3: normalise, round, pack ----------------
    function automatic logic [XW-1:0] f_lzc(input logic [AW-1:0] v);
        logic [XW-1:0] n;
        logic          done;
        n    = '0;
        done = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + XONE;
            end
        end
        return n;
    endfunction

    logic [XW-1:0] w_lz, w_sh, w_en, w_er;
    logic [AW-1:0] w_norm;
    logic [M-1:0]  w_mant;
    logic [M:0]    w_rnd;
    logic          w_g, w_st, w_inexact, w_inc, w_hid, w_zero, w_ovf;
    logic [SIG_W-1:0] w_frac;
    logic [FW-1:0] w_res;
    logic [2:0]    w_err;

    assign w_lz = f_lzc(r2_sum[AW-1:0]);

    always_comb begin
        w_sh   = '0;
        w_norm = '0;
        w_en   = '0;
        if (r2_sum[SW-1]) begin
            w_norm = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
            w_en   = r2_exp + XONE;
        end else begin
            // Normalisation stops at exponent 1, leaving a denormal.
            w_sh   = (w_lz < r2_exp) ? w_lz : (r2_exp - XONE);
            w_norm = r2_sum[AW-1:0] << w_sh;
            w_en   = r2_exp - w_sh;
        end
    end

    assign w_mant    = w_norm[AW-1:3];
    assign w_g       = w_norm[2];
    assign w_st      = w_norm[1] | w_norm[0];
    assign w_inexact = w_g | w_st;
    assign w_inc     = !r2_rm && w_g && (w_st || w_mant[0]);
    assign w_rnd     = {1'b0, w_mant} + {{M{1'b0}}, w_inc};
    assign w_er      = w_rnd[M] ? (w_en + XONE) : w_en;
    assign w_hid     = w_rnd[M] | w_rnd[M-1];
    assign w_frac    = w_rnd[M] ? '0 : w_rnd[SIG_W-1:0];
    assign w_zero    = (r2_sum == '0);
    assign w_ovf     = (w_er >= EMAX);

    always_comb begin
        w_res = '0;
        w_err = ERR_NONE;
        if (r2_spec) begin
            w_res = r2_spec_val;
            w_err = r2_spec_err;
        end else if (w_zero) begin
            w_res = {r2_sign && !r2_sub, {(FW-1){1'b0}}};
        end else if (w_ovf) begin
            w_err = ERR_OVF;
            w_res = r2_rm ? {r2_sign, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}}
                          : {r2_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
        end else begin
            w_res = {r2_sign, (w_hid ? w_er[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
            w_err = (!w_hid && w_inexact) ? ERR_UNF : ERR_NONE;
        end
    end

    // The whole pipe stalls together so in_ready is simply the advance term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_spec_val <= '0;
            r1_spec_err <= ERR_NONE;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_rm       <= 1'b0;
            r1_exp      <= '0;
            r1_mb       <= '0;
            r1_ms       <= '0;
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_spec_val <= '0;
            r2_spec_err <= ERR_NONE;
            r2_sign     <= 1'b0;
            r2_sub      <= 1'b0;
            r2_rm       <= 1'b0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            out_valid   <= 1'b0;
            fp_out      <= '0;
            err_o       <= ERR_NONE;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_spec     <= w_spec;
            r1_spec_val <= w_spec_val;
            r1_spec_err <= w_spec_err;
            r1_sign     <= w_sb;
            r1_sub      <= sign1 ^ w_s2e;
            r1_rm       <= rm;
            r1_exp      <= w_eb;
            r1_mb       <= {w_mb, 3'b000};
            r1_ms       <= w_small;
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_spec_val <= r1_spec_val;
            r2_spec_err <= r1_spec_err;
            r2_sign     <= r1_sign;
            r2_sub      <= r1_sub;
            r2_rm       <= r1_rm;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            out_valid   <= r2_valid;
            fp_out      <= w_res;
            err_o       <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Brief    : Directed-vector scoreboard bench for fp_addsub_pipe (binary32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        opcode = 1'b0, sign1 = 1'b0, sign2 = 1'b0, rm = 1'b0;
    logic [7:0]  exp1 = '0, exp2 = '0;
    logic [22:0] sig1 = '0, sig2 = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] fp_out;
    logic [2:0]  err_o;

    fp_addsub_pipe #(.EXP_W(8), .SIG_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
        .sig1(sig1), .sig2(sig2), .rm(rm), .out_valid(out_valid),
        .out_ready(out_ready), .fp_out(fp_out), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [2:0]  err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    bit   saw_full = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks holds.
    bit          hold_prev = 1'b0;
    logic [31:0] prev_fp;
    logic [2:0]  prev_err;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", {29'd0, fp_out, err_o}, {29'd0, prev_fp, prev_err});
            end
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %h required none", fp_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check({e.nm, "_res"}, 64'(fp_out), 64'(e.res));
                    check({e.nm, "_err"}, 64'(err_o), 64'(e.err));
                    if (e.lat >= 0) check({e.nm, "_lat"}, 64'(cyc - e.lat), 64'd3);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_fp   = fp_out;
            prev_err  = err_o;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input string nm, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input logic [31:0] res,
                         input logic [2:0] er, input bit push, input bit lat);
        int k;
        in_valid = 1'b1; opcode = op; rm = r;
        sign1 = a[31]; exp1 = a[30:23]; sig1 = a[22:0];
        sign2 = b[31]; exp2 = b[30:23]; sig2 = b[22:0];
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL %s_accept: got in_ready 0 required 1", nm);
        end else if (push) begin
            q.push_back('{nm, res, er, (lat ? cyc : -1)});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending required 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fp_out", 64'(fp_out), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        issue("one_plus_two", 0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'd0, 1, 1);
        drain();

        issue("rne_up",    0, 32'h3F800000, 32'h33C00000, 0, 32'h3F800001, 3'd0, 1, 1);
        issue("rtz_trunc", 0, 32'h3F800000, 32'h33C00000, 1, 32'h3F800000, 3'd0, 1, 1);
        issue("rne_tie",   0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'd0, 1, 1);
        issue("ovf_rne",   0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'd1, 1, 1);
        issue("ovf_rtz",   0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1, 32'h7F7FFFFF, 3'd1, 1, 1);
        issue("inf_m_inf", 1, 32'h7F800000, 32'h7F800000, 0, 32'h7FC00000, 3'd3, 1, 1);
        issue("exact_zero",1, 32'h3F800000, 32'h3F800000, 0, 32'h00000000, 3'd0, 1, 1);
        issue("denorm",    1, 32'h00800000, 32'h00400000, 0, 32'h00400000, 3'd0, 1, 1);
        issue("neg_zeros", 0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 3'd0, 1, 1);
        issue("nan_in",    0, 32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 3'd3, 1, 1);
        issue("one_m_inf", 1, 32'h3F800000, 32'h7F800000, 0, 32'hFF800000, 3'd0, 1, 1);
        drain();

        saw_full = 1'b0;
        fork
            begin
                issue("bb0", 0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 3'd0, 1, 0);
                issue("bb1", 1, 32'h40000000, 32'h3F800000, 0, 32'h3F800000, 3'd0, 1, 0);
                issue("bb2", 1, 32'h40400000, 32'h3F800000, 0, 32'h40000000, 3'd0, 1, 0);
                issue("bb3", 0, 32'h3FC00000, 32'h3F000000, 0, 32'h40000000, 3'd0, 1, 0);
                issue("bb4", 0, 32'hBF800000, 32'hBF800000, 0, 32'hC0000000, 3'd0, 1, 0);
                issue("bb5", 0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'd0, 1, 0);
            end
            begin
                repeat (2) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped", 64'(saw_full), 64'd1);

        issue("flush0", 0, 32'h3F800000, 32'h3F800000, 0, 32'h0, 3'd0, 0, 0);
        issue("flush1", 0, 32'h3F800000, 32'h3F800000, 0, 32'h0, 3'd0, 0, 0);
        issue("flush2", 0, 32'h3F800000, 32'h3F800000, 0, 32'h0, 3'd0, 0, 0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_fp", 64'(fp_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        issue("post_rst", 0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'd0, 1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
